// File: rtl/async_fifo.sv
// Single-clock FIFO with registered flags-from-count, watermarks and a
// standard or first-word-fall-through read port; storage style is selectable.
module async_fifo #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 4,
  parameter string RAM_STYLE  = "distributed",
  parameter int    TH_WR      = 1,
  parameter int    TH_RD      = 1,
  parameter int    FWFT_EN    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty
);

  localparam int              DEPTH    = 2 ** ADDR_WIDTH;
  localparam int              CW       = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]   AF_LEVEL = CW'(DEPTH - TH_WR);
  localparam logic [CW-1:0]   AE_LEVEL = CW'(TH_RD);
  localparam logic [CW-1:0]   ONE_C    = CW'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr_nxt;
  logic [CW-1:0]         count;
  logic                  do_wr;
  logic                  do_rd;
  logic [DATA_WIDTH-1:0] head_word;
  logic [DATA_WIDTH-1:0] next_word;
  logic [DATA_WIDTH-1:0] dout_nxt;

  // Handshake: a request is accepted only when its side is not blocked;
  // full blocks writes, empty blocks reads, each independently.
  assign do_wr      = wr_en && !full;
  assign do_rd      = rd_en && !empty;
  assign rd_ptr_nxt = rd_ptr + 1'b1;

  generate
    if (RAM_STYLE == "block") begin : g_ram
      (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
      end
      assign head_word = mem[rd_ptr];
      assign next_word = mem[rd_ptr_nxt];
    end else begin : g_ram
      (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
      end
      assign head_word = mem[rd_ptr];
      assign next_word = mem[rd_ptr_nxt];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr_nxt;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (do_rd && !do_wr) count <= count - 1'b1;
    end
  end

  // FWFT keeps dout equal to the head word: on a read it loads the word
  // behind the head, or bypasses din when that word is being written now.
  always_comb begin
    dout_nxt = dout;
    if (FWFT_EN != 0) begin
      if (do_rd) begin
        if (count > ONE_C) dout_nxt = next_word;
        else if (do_wr)    dout_nxt = din;
      end else if (empty && do_wr) begin
        dout_nxt = din;
      end
    end else if (do_rd) begin
      dout_nxt = head_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else        dout <= dout_nxt;
  end

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_LEVEL);
  assign almost_empty = (count <= AE_LEVEL);

endmodule

// File: tb/tb_async_fifo.sv
// Drives one stimulus stream into a standard-mode and an FWFT-mode FIFO and
// checks both against a queue model of the stored words.
module tb_async_fifo;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;

  logic [DW-1:0] dout_s, dout_f;
  logic          full_s, afull_s, empty_s, aempty_s;
  logic          full_f, afull_f, empty_f, aempty_f;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_std;
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  async_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_STYLE("block"),
               .TH_WR(1), .TH_RD(1), .FWFT_EN(0)) u_std (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .full(full_s),
    .almost_full(afull_s), .dout(dout_s), .rd_en(rd_en), .empty(empty_s),
    .almost_empty(aempty_s)
  );

  async_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_STYLE("distributed"),
               .TH_WR(1), .TH_RD(1), .FWFT_EN(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .full(full_f),
    .almost_full(afull_f), .dout(dout_f), .rd_en(rd_en), .empty(empty_f),
    .almost_empty(aempty_f)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_flags(input int size);
    check_eq("std_full",    full_s,   size == DEPTH);
    check_eq("std_afull",   afull_s,  size >= DEPTH - 1);
    check_eq("std_empty",   empty_s,  size == 0);
    check_eq("std_aempty",  aempty_s, size <= 1);
    check_eq("fwft_full",   full_f,   size == DEPTH);
    check_eq("fwft_afull",  afull_f,  size >= DEPTH - 1);
    check_eq("fwft_empty",  empty_f,  size == 0);
    check_eq("fwft_aempty", aempty_f, size <= 1);
  endtask

  task automatic check_state();
    check_flags(exp_q.size());
    if (exp_q.size() > 0) check_eq("fwft_head", dout_f, exp_q[0]);
  endtask

  // One clock of stimulus: check settled state, drive, then update model.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    logic dw, dr;
    @(negedge clk);
    check_state();
    wr_en = w;
    din   = d;
    rd_en = r;
    dw = w && (exp_q.size() < DEPTH);
    dr = r && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    if (dr) last_std = exp_q.pop_front();
    if (dw) exp_q.push_back(d);
    check_eq("std_dout", dout_s, last_std);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    last_std = '0;
    #1;
    check_flags(0);
    check_eq("rst_dout_std", dout_s, 0);
    check_eq("rst_dout_fwft", dout_f, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill past full: words 17..20 must be dropped.
    for (int i = 1; i <= 20; i++) step(1'b1, DW'(i), 1'b0);
    // Drain past empty: extra reads leave dout holding the last word.
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);

    // Single word into an empty FIFO, then consume it.
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Steady state at occupancy 8 with both sides active, crossing wrap.
    for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 40; i++)
      step(1'b1, DW'($urandom_range(0, 255)), 1'b1);

    // Mixed random traffic.
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)));

    // Bring occupancy to 10, then reset between clock edges.
    while (exp_q.size() < 10) step(1'b1, DW'($urandom_range(0, 255)), 1'b0);
    while (exp_q.size() > 10) step(1'b0, '0, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    last_std = '0;
    check_flags(0);
    check_eq("arst_dout_std", dout_s, 0);
    check_eq("arst_dout_fwft", dout_f, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    check_eq("post_rst_std", dout_s, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
